// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register map, CTRL fields, mode codes and FSM states shared by the timer
package mmio_timer_pkg;
   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PRESET = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;
   localparam logic [1:0] TMR_ONESHOT = 2'b00;
   localparam logic [1:0] TMR_RELOAD  = 2'b01;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tmr_state_t;
endpackage

// File: rtl/mmio_timer_fsm.sv
// timer_fsm: countdown state machine owning COUNT and the pending-interrupt flag
module timer_fsm
   import mmio_timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             reload,
   input  logic [CNT_W-1:0] preset,
   input  logic             wclr,
   output logic [CNT_W-1:0] count,
   output logic             irq_pend,
   output logic             en_clr
);
   tmr_state_t state, state_nxt;
   logic irq_set;
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= ST_IDLE;
      else state <= state_nxt;
   // next state: a count of 1 or 0 both expire so the counter never wraps
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = en ? ST_LOAD : ST_IDLE;
         ST_LOAD: state_nxt = ST_CNT;
         ST_CNT:  state_nxt = !en ? ST_IDLE : (count > CNT_W'(1)) ? ST_CNT : ST_INT;
         ST_INT:  state_nxt = reload ? ST_LOAD : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end
   // outputs decoded from state: expiry raises the pend flag, one-shot expiry drops EN
   always_comb begin
      irq_set = state == ST_INT;
      en_clr  = state == ST_INT && !reload;
   end
   // COUNT: loaded in LOAD, decremented in CNT while enabled, held otherwise
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (state == ST_LOAD) count <= preset;
      else if (state == ST_CNT && en) count <= (count > CNT_W'(1)) ? count - CNT_W'(1) : '0;
   // pending flag: a software write in the same cycle as expiry wins
   always_ff @(posedge clk or posedge reset)
      if (reset) irq_pend <= 1'b0;
      else if (wclr) irq_pend <= 1'b0;
      else if (irq_set) irq_pend <= 1'b1;
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT); TIMER_AUTORELOAD_EN enables auto-reload mode
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   logic             en, im, irq_pend, en_clr, wr_ctrl, wr_pre;
   logic [1:0]       mode;
   logic [CNT_W-1:0] preset, count;
   logic             unused_addr;
   assign unused_addr = &{1'b0, addr[31:4], addr[1:0]};
   assign wr_ctrl = sel && we && addr[3:2] == TMR_CTRL;
   assign wr_pre  = sel && we && addr[3:2] == TMR_PRESET;
   assign irq     = im & irq_pend;
   // CTRL EN/IM: a CPU write outranks the FSM's one-shot EN clear
   always_ff @(posedge clk or posedge reset)
      if (reset) {en, im} <= 2'b00;
      else if (wr_ctrl) {en, im} <= {wdata[CTRL_EN], wdata[CTRL_IM]};
      else if (en_clr) en <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
   // CTRL MODE field
   always_ff @(posedge clk or posedge reset)
      if (reset) mode <= TMR_ONESHOT;
      else if (wr_ctrl) mode <= wdata[CTRL_MODE+:2];
`else
   assign mode = TMR_ONESHOT;
`endif
   // PRESET storage; a write mid-count only matters at the next LOAD
   always_ff @(posedge clk or posedge reset)
      if (reset) preset <= '0;
      else if (wr_pre) preset <= wdata[CNT_W-1:0];
   // read mux, independent of sel
   always_comb
      rdata = addr[3:2] == TMR_CTRL   ? {28'd0, im, mode, en} :
              addr[3:2] == TMR_PRESET ? 32'(preset) :
              addr[3:2] == TMR_COUNT  ? 32'(count) : 32'd0;
   timer_fsm #(.CNT_W(CNT_W)) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .reload   (mode == TMR_RELOAD),
      .preset   (preset),
      .wclr     (wr_ctrl || wr_pre),
      .count    (count),
      .irq_pend (irq_pend),
      .en_clr   (en_clr)
   );
endmodule
